// File: rtl/pattern_match_sched.sv
// Round-robin scheduler and sequencer sharing one pattern_match datapath
// between NREQ requesters: grant, clear, run, capture, respond.
module pattern_match_sched #(
  parameter int unsigned N         = 16,
  parameter int unsigned M         = 4,
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MATCH_LAT = 16,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CW  = $clog2(N + 1),
  localparam int unsigned FW  = $clog2(N),
  localparam int unsigned LW  = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_text,
  input  logic [NREQ*M-1:0] req_pattern,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [0:N-1]      rsp_flag,
  output logic [CW-1:0]     rsp_count,
  output logic [FW-1:0]     rsp_first,
  output logic              rsp_none,
  output logic              pm_reset,
  output logic              pm_enable,
  output logic [0:N-1]      pm_text,
  output logic [0:M-1]      pm_pattern,
  input  logic [0:N-1]      pm_flag
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, CAP, RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [0:N-1]   text_q, text_d;
  logic [0:M-1]   pat_q, pat_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic [0:N-1]   flag_q, flag_d;
  logic [CW-1:0]  count_q, count_d;
  logic [FW-1:0]  first_q, first_d;
  logic           none_q, none_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [CW-1:0]  pop_c;
  logic [FW-1:0]  first_c;
  logic           first_found;

  // Round-robin pick: first valid requester after the last one granted
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!gnt_found && req_valid[k] && (k == (32'(last_q) + off) % NREQ)) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(k);
        end
      end
    end
  end

  // Population count and lowest set index of the matcher flags
  always_comb begin
    pop_c       = '0;
    first_c     = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pm_flag[i]) begin
        pop_c = pop_c + CW'(1);
        if (!first_found) begin
          first_c     = FW'(i);
          first_found = 1'b1;
        end
      end
    end
  end

  // Next-state and job/result latch updates
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    text_d  = text_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    count_d = count_q;
    first_d = first_q;
    none_d  = none_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          last_d  = gnt_idx;
          id_d    = gnt_idx;
          for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
              text_d = req_text[k*N +: N];
              pat_d  = req_pattern[k*M +: M];
            end
          end
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d   = LW'(MATCH_LAT - 1);
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_d = CAP;
        else             cnt_d   = cnt_q - LW'(1);
      end
      CAP: begin
        flag_d  = pm_flag;
        count_d = pop_c;
        first_d = first_c;
        none_d  = (pop_c == '0);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      text_q  <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= '0;
      count_q <= '0;
      first_q <= '0;
      none_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      text_q  <= text_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      first_q <= first_d;
      none_q  <= none_d;
    end
  end

  // Handshake and matcher control decoded from the state register
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && reset && gnt_found) req_ready = NREQ'(1) << gnt_idx;
  end

  assign rsp_valid  = (state_q == RESP);
  assign pm_enable  = (state_q == RUN) || (state_q == CAP);
  assign pm_reset   = !reset || (state_q == CLR);
  assign pm_text    = text_q;
  assign pm_pattern = pat_q;
  assign rsp_id     = id_q;
  assign rsp_flag   = flag_q;
  assign rsp_count  = count_q;
  assign rsp_first  = first_q;
  assign rsp_none   = none_q;

endmodule

// File: tb/tb_pattern_match_sched.sv
// Scoreboard bench for pattern_match_sched with a behavioural matcher.
module tb_pattern_match_sched;
  localparam int unsigned N = 16, M = 4, NREQ = 2, MATCH_LAT = 16;
  localparam int unsigned IDW = 1, CW = 5, FW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_text = '0;
  logic [NREQ*M-1:0] req_pattern = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [0:N-1]      rsp_flag;
  logic [CW-1:0]     rsp_count;
  logic [FW-1:0]     rsp_first;
  logic              rsp_none;
  logic              pm_reset, pm_enable;
  logic [0:N-1]      pm_text;
  logic [0:M-1]      pm_pattern;
  logic [0:N-1]      pm_flag;

  pattern_match_sched #(.N(N), .M(M), .NREQ(NREQ), .MATCH_LAT(MATCH_LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_text(req_text), .req_pattern(req_pattern), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_flag(rsp_flag), .rsp_count(rsp_count),
    .rsp_first(rsp_first), .rsp_none(rsp_none), .pm_reset(pm_reset), .pm_enable(pm_enable),
    .pm_text(pm_text), .pm_pattern(pm_pattern), .pm_flag(pm_flag)
  );

  always #5 clock = ~clock;

  // Behavioural matcher: flags valid only after MATCH_LAT enabled cycles since clear
  int en_cnt = 0;
  always @(posedge clock) begin
    if (pm_reset) en_cnt <= 0;
    else if (pm_enable) en_cnt <= en_cnt + 1;
  end
  always @* begin
    pm_flag = '0;
    if (en_cnt >= MATCH_LAT)
      for (int i = 0; i <= N - M; i++) pm_flag[i] = (pm_text[i +: M] == pm_pattern);
  end

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int          id;
    logic [N-1:0] flag;   // bit N-1 is flag index 0
    int          count;
    int          first;
    bit          none;
    int          due;
  } exp_t;

  // Reference: slide an M-bit window across the text from the leftmost bit
  function automatic exp_t model(int id, logic [N-1:0] t, logic [M-1:0] p, int due);
    exp_t e;
    logic [M-1:0] w;
    e.id = id; e.flag = '0; e.count = 0; e.first = 0; e.due = due;
    for (int i = 0; i <= N - M; i++) begin
      w = M'(t >> (N - M - i));
      if (w == p) begin
        e.flag[N-1-i] = 1'b1;
        if (e.count == 0) e.first = i;
        e.count++;
      end
    end
    e.none = (e.count == 0);
    return e;
  endfunction

  exp_t q[$];
  bit   busy = 1'b0;
  int   last = NREQ - 1;
  bit   prev_v = 1'b0;
  int   gnt_log[$];
  int   rsp_cyc[$];
  int   n_rsp = 0;
  logic [N-1:0] lr_flag;
  int   lr_id, lr_count, lr_first;
  bit   lr_none;

  // Monitor: arbitration model, response scoreboard, latency and stability
  always @(negedge clock) begin
    logic [NREQ-1:0] exp_rdy;
    int g;
    if (!reset) begin
      q.delete(); busy = 1'b0; last = NREQ - 1; prev_v = 1'b0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!busy)
        for (int o = 1; o <= NREQ; o++)
          if (g < 0 && req_valid[(last + o) % NREQ]) g = (last + o) % NREQ;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (rsp_valid) begin
        if (q.size() == 0) fail_now("rsp_valid_without_job");
        else begin
          if (!prev_v) chk("rsp_latency", cyc, q[0].due);
          chk("rsp_id", rsp_id, q[0].id);
          chk("rsp_flag", rsp_flag, q[0].flag);
          chk("rsp_count", rsp_count, q[0].count);
          chk("rsp_first", rsp_first, q[0].first);
          chk("rsp_none", rsp_none, q[0].none);
          if (rsp_ready) begin
            lr_flag = rsp_flag; lr_id = rsp_id; lr_count = rsp_count;
            lr_first = rsp_first; lr_none = rsp_none;
            n_rsp++;
            rsp_cyc.push_back(cyc);
            void'(q.pop_front());
            busy = 1'b0;
          end
        end
      end
      prev_v = rsp_valid;
      if (g >= 0) begin
        q.push_back(model(g, req_text[g*N +: N], req_pattern[g*M +: M], cyc + MATCH_LAT + 3));
        gnt_log.push_back(g);
        busy = 1'b1;
        last = g;
      end
    end
  end

  task automatic wait_acc(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (req_valid[k] && req_ready[k]) ok = 1'b1;
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clock); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [N-1:0] t, input logic [M-1:0] p);
    @(posedge clock); #1;
    req_text[k*N +: N] = t;
    req_pattern[k*M +: M] = p;
    req_valid[k] = 1'b1;
    wait_acc(k);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock); #2;
      if (!busy && q.size() == 0 && !rsp_valid) ok = 1'b1;
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic new_job(input int k);
    logic [M-1:0] p;
    p = M'($urandom);
    req_pattern[k*M +: M] = p;
    if ($urandom_range(0, 3) == 0) req_text[k*N +: N] = {4{p}};
    else req_text[k*N +: N] = N'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] acc;
    int saved;
    // Reset values, with requests pending so req_ready gating is exercised
    #2 reset = 1'b0;
    req_valid = '1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_flag", rsp_flag, 0);
    chk("reset_rsp_count", rsp_count, 0);
    chk("reset_rsp_first", rsp_first, 0);
    chk("reset_rsp_none", rsp_none, 1);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_pm_enable", pm_enable, 0);
    chk("reset_pm_reset", pm_reset, 1);
    chk("reset_pm_text", pm_text, 0);
    chk("reset_pm_pattern", pm_pattern, 0);
    req_valid = '0;
    @(negedge clock); #2 reset = 1'b1;
    rsp_ready = 1'b1;

    // All-ones text and pattern
    send(0, 16'hFFFF, 4'hF);
    wait_idle();
    chk("t1_flag", lr_flag, 16'hFFF8);
    chk("t1_count", lr_count, 13);
    chk("t1_first", lr_first, 0);
    chk("t1_id", lr_id, 0);

    // Single match at the rightmost window
    send(1, 16'h000B, 4'hB);
    wait_idle();
    chk("t2_flag", lr_flag, 16'h0008);
    chk("t2_count", lr_count, 1);
    chk("t2_first", lr_first, 12);
    chk("t2_id", lr_id, 1);

    // No match
    send(0, 16'h0000, 4'hF);
    wait_idle();
    chk("t3_none", lr_none, 1);
    chk("t3_count", lr_count, 0);
    chk("t3_first", lr_first, 0);

    // Both requesters continuously valid
    gnt_log.delete(); rsp_cyc.delete();
    @(posedge clock); #1;
    new_job(0); new_job(1);
    req_valid = '1;
    for (int i = 0; i < 200 && rsp_cyc.size() < 4; i++) begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock); #1;
      for (int k = 0; k < NREQ; k++) if (acc[k]) new_job(k);
    end
    req_valid = '0;
    wait_idle();
    if (rsp_cyc.size() < 4 || gnt_log.size() < 4) fail_now("continuous_responses");
    else
      for (int i = 1; i < 4; i++) begin
        chk("rr_alternate", gnt_log[i], gnt_log[i-1] ^ 1);
        chk("rsp_spacing", rsp_cyc[i] - rsp_cyc[i-1], MATCH_LAT + 4);
      end

    // Back-pressure: response held while another request waits
    rsp_ready = 1'b0;
    send(1, 16'hA5A5, 4'h5);
    @(posedge clock); #1;
    new_job(0);
    req_valid[0] = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clock);
        if (rsp_valid) seen = 1'b1;
      end
      if (!seen) fail_now("stall_rsp_timeout");
    end
    repeat (10) @(negedge clock);
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("grant_after_stall", req_ready, 2'b01);
    @(posedge clock); #1 req_valid[0] = 1'b0;
    wait_idle();

    // Reset in the middle of RUN; requester 0 owns the aborted job
    send(0, 16'hFFFF, 4'h3);
    repeat (5) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("midrst_pm_reset", pm_reset, 1);
    chk("midrst_pm_enable", pm_enable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    saved = n_rsp;
    @(negedge clock);
    @(posedge clock); #3 reset = 1'b1;
    repeat (30) @(negedge clock);
    chk("midrst_no_rsp", n_rsp, saved);
    // Pointer reinitialised: requester 0 wins again over requester 1
    gnt_log.delete();
    @(posedge clock); #1;
    req_text = {16'h1234, 16'h3333};
    req_pattern = {4'h3, 4'h3};
    req_valid = '1;
    for (int i = 0; i < 200 && gnt_log.size() < 2; i++) begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock); #1;
      req_valid = req_valid & ~acc;
    end
    req_valid = '0;
    wait_idle();
    if (gnt_log.size() < 2) fail_now("post_reset_grants");
    else chk("post_reset_first_grant", gnt_log[0], 0);

    // Randomised traffic with drops and back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc[k]) begin
          req_valid[k] = 1'b0;
          if ($urandom_range(0, 1) == 0) begin new_job(k); req_valid[k] = 1'b1; end
        end else if (req_valid[k] && $urandom_range(0, 39) == 0) begin
          req_valid[k] = 1'b0;
        end else if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
          new_job(k); req_valid[k] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
